// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 shared types, constants and byte-level round helpers
// Purpose: FSM encoding, block/round constants and the SubBytes/ShiftRows/MixColumns
//          functions shared by the round datapath modules. Blocks are big-endian
//          [0:127]; byte n occupies bits [8n:8n+7] and bytes are column-major (r + 4c).
package aes_pkg;

  localparam int AES_B     = 128;
  localparam int AES128_NR = 10;
  localparam int AES128_NK = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_FINAL, ST_DONE} aes_fsm_t;
  typedef logic [0:AES_B-1] aes_block_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as the GF(2^8) inverse (a^254, which maps 0 to 0) followed by
  // the affine transform, instead of storing a 256-entry table.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, v;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    v    = gf_mul(x252, x2);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic aes_block_t sub_bytes(input aes_block_t s);
    aes_block_t r;
    for (int n = 0; n < 16; n++) r[8*n +: 8] = sbox(s[8*n +: 8]);
    return r;
  endfunction

  // Row r of column c takes the byte from column (c + r) mod 4.
  function automatic aes_block_t shift_rows(input aes_block_t s);
    aes_block_t r;
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++)
        r[8*(row + 4*col) +: 8] = s[8*(row + 4*((col + row) % 4)) +: 8];
    return r;
  endfunction

  function automatic aes_block_t mix_columns(input aes_block_t s);
    aes_block_t r;
    logic [7:0] a0, a1, a2, a3;
    for (int col = 0; col < 4; col++) begin
      a0 = s[8*(4*col)     +: 8];
      a1 = s[8*(4*col + 1) +: 8];
      a2 = s[8*(4*col + 2) +: 8];
      a3 = s[8*(4*col + 3) +: 8];
      r[8*(4*col)     +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[8*(4*col + 1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[8*(4*col + 2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[8*(4*col + 3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_final_round.sv
// rtl/aes_final_round.sv - last AES round: SubBytes, ShiftRows, AddRoundKey (no MixColumns)
// Ports: in  [0:127] state entering round Nr
//        key [0:127] round key Nr
//        out [0:127] ciphertext (combinational)
module aes_final_round
  import aes_pkg::*;
(
  input  logic [0:AES_B-1] in,
  input  logic [0:AES_B-1] key,
  output logic [0:AES_B-1] out
);

  assign out = shift_rows(sub_bytes(in)) ^ key;

endmodule

// File: rtl/encryptionRound.sv
// rtl/encryptionRound.sv - one full AES round: SubBytes, ShiftRows, MixColumns, AddRoundKey
// Ports: in  [0:127] round input state
//        key [0:127] round key
//        out [0:127] round output state (combinational)
module encryptionRound
  import aes_pkg::*;
(
  input  logic [0:AES_B-1] in,
  input  logic [0:AES_B-1] key,
  output logic [0:AES_B-1] out
);

  assign out = mix_columns(shift_rows(sub_bytes(in))) ^ key;

endmodule

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - iterative AES-128 encryption controller, one round per cycle
// Ports: clk, reset (async, active-high)
//        in_valid/in_ready, data_in [0:127], round_keys [0:128*(Nr+1)-1] (rk_i at [128i +: 128])
//        out_valid/out_ready, data_out [0:127] (the state register)
//        busy (ROUND or FINAL), round_idx [3:0] (0 in IDLE/DONE)
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int B  = AES_B,
  parameter int Nr = AES128_NR,
  parameter int Nk = AES128_NK
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [0:B-1]          data_in,
  input  logic [0:B*(Nr+1)-1]   round_keys,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:B-1]          data_out,
  output logic                  busy,
  output logic [3:0]            round_idx
);

  localparam logic [3:0] LAST_MID = 4'(Nr - 1);

  // The key schedule arrives fully expanded, so Nk plays no part in control;
  // only the AES-128 value is meaningful and other values leave this block empty.
  if (Nk != AES128_NK) begin : g_nk_unused
  end

  aes_fsm_t     fsm_q, fsm_d;
  logic [0:B-1] state_q;
  logic [3:0]   round_q;
  logic [0:B-1] rk_sel;
  logic [0:B-1] mid_out;
  logic [0:B-1] final_out;

  // round_q is 0 in IDLE (rk0 for the initial AddRoundKey), 1..Nr-1 in ROUND and
  // Nr in FINAL, so one mux serves every stage.
  always_comb begin
    rk_sel = round_keys[0 +: B];
    for (int i = 1; i <= Nr; i++)
      if (round_q == 4'(i)) rk_sel = round_keys[i*B +: B];
  end

  encryptionRound u_round (
    .in  (state_q),
    .key (rk_sel),
    .out (mid_out)
  );

  aes_final_round u_final (
    .in  (state_q),
    .key (rk_sel),
    .out (final_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fsm_q <= ST_IDLE;
    else       fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE:  if (in_valid) fsm_d = ST_ROUND;
      ST_ROUND: if (round_q == LAST_MID) fsm_d = ST_FINAL;
      ST_FINAL: fsm_d = ST_DONE;
      ST_DONE:  if (out_ready) fsm_d = ST_IDLE;
      default:  fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= '0;
      round_q <= '0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_q <= data_in ^ rk_sel;
            round_q <= 4'd1;
          end
        end
        ST_ROUND: begin
          state_q <= mid_out;
          round_q <= round_q + 4'd1;
        end
        ST_FINAL: begin
          state_q <= final_out;
          round_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (fsm_q == ST_IDLE);
  assign out_valid = (fsm_q == ST_DONE);
  assign busy      = (fsm_q == ST_ROUND) || (fsm_q == ST_FINAL);
  assign data_out  = state_q;
  assign round_idx = round_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - directed FIPS-197 vector bench for aes_round_sequencer
module tb_aes_round_sequencer;

  localparam int NR = 10;
  localparam int KW = 128 * (NR + 1);

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [0:127]    data_in;
  logic [0:KW-1]   round_keys;
  logic            out_valid;
  logic            out_ready;
  logic [0:127]    data_out;
  logic            busy;
  logic [3:0]      round_idx;

  always #5 clk = ~clk;

  aes_round_sequencer #(.B(128), .Nr(NR), .Nk(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .round_keys (round_keys),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .busy       (busy),
    .round_idx  (round_idx)
  );

  localparam logic [0:127] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] PT_C = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  localparam logic [0:KW-1] KS_B = {
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

  localparam logic [0:KW-1] KS_C = {
    128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5};

  typedef struct {
    logic [0:127]  pt;
    logic [0:127]  ct;
    logic [0:KW-1] ks;
    int            hold;    // cycles out_ready stays low in DONE
    int            glitch;  // round at which a stray in_valid pulse is driven (0 = none)
  } vec_t;

  vec_t vecs[4];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_block(input vec_t v);
    int waited;
    @(negedge clk);
    waited = 0;
    while (!in_ready && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    data_in    = v.pt;
    round_keys = v.ks;
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= NR - 1; k++) begin
      chk($sformatf("round_idx_r%0d", k), round_idx, k);
      chk($sformatf("busy_r%0d", k), busy, 1);
      chk($sformatf("in_ready_r%0d", k), in_ready, 0);
      if (k == v.glitch) begin
        in_valid = 1'b1;
        data_in  = ~v.pt;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("round_idx_final", round_idx, NR);
    chk("busy_final", busy, 1);
    chk("out_valid_final", out_valid, 0);
    @(negedge clk);
    chk("out_valid_latency", out_valid, 1);
    chk("data_out", data_out, v.ct);
    chk("busy_done", busy, 0);
    chk("round_idx_done", round_idx, 0);
    for (int h = 0; h < v.hold; h++) begin
      in_valid = 1'b1;
      data_in  = ~v.pt;
      @(negedge clk);
      chk($sformatf("out_valid_hold%0d", h), out_valid, 1);
      chk($sformatf("data_out_hold%0d", h), data_out, v.ct);
      chk($sformatf("in_ready_hold%0d", h), in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_ready", out_valid, 0);
    chk("in_ready_after_ready", in_ready, 1);
    chk("round_idx_idle", round_idx, 0);
  endtask

  initial begin
    int acc_cyc[2];
    int res_cyc[2];
    int n_acc;
    int n_res;
    int waited;
    logic [0:127] exp_ct[2];

    vecs[0] = '{PT_B, CT_B, KS_B, 0, 0};
    vecs[1] = '{PT_C, CT_C, KS_C, 5, 0};
    vecs[2] = '{PT_B, CT_B, KS_B, 2, 4};
    vecs[3] = '{PT_C, CT_C, KS_C, 0, 7};

    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    data_in    = '0;
    round_keys = '0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_data_out", data_out, 0);
    chk("reset_round_idx", round_idx, 0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) run_block(vecs[i]);

    // Back-to-back with in_valid and out_ready held high.
    @(negedge clk);
    n_acc = 0;
    n_res = 0;
    exp_ct[0] = CT_B;
    exp_ct[1] = CT_C;
    data_in    = PT_B;
    round_keys = KS_B;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (in_valid && in_ready && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      if (out_valid && n_res < 2) begin
        chk($sformatf("b2b_data_out%0d", n_res), data_out, exp_ct[n_res]);
        res_cyc[n_res] = cyc;
        n_res++;
        if (n_res == 1) begin
          data_in    = PT_C;
          round_keys = KS_C;
        end
      end
      if (n_acc == 2 && !in_ready) in_valid = 1'b0;
      if (n_res == 2) break;
      @(negedge clk);
    end
    chk("b2b_accepts", n_acc, 2);
    chk("b2b_results", n_res, 2);
    if (n_acc == 2) chk("b2b_accept_spacing", acc_cyc[1] - acc_cyc[0], NR + 2);
    if (n_res == 2) chk("b2b_latency", res_cyc[1] - acc_cyc[1], NR + 1);
    @(negedge clk);
    chk("b2b_out_valid_one_cycle", out_valid, 0);
    out_ready = 1'b0;
    in_valid  = 1'b0;

    // Reset asserted mid-operation at round 5.
    @(negedge clk);
    data_in    = PT_B;
    round_keys = KS_B;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    waited = 0;
    while (round_idx != 4'd5 && waited < 15) begin
      @(negedge clk);
      waited++;
    end
    chk("mid_reset_reached_r5", round_idx, 5);
    #1 reset = 1'b1;
    #1;
    chk("mid_reset_out_valid", out_valid, 0);
    chk("mid_reset_data_out", data_out, 0);
    chk("mid_reset_in_ready", in_ready, 1);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_round_idx", round_idx, 0);
    @(negedge clk);
    reset = 1'b0;
    run_block(vecs[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
